// File: rtl/rv_pkg.sv
// Shared fetch-stage constants, instruction field positions and the fetch FSM encoding.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential pc+4 or a datapath target, plus the alignment check.
module pc_next
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pc_source,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);
  assign pc_plus4   = pc + XLEN'(4);
  assign next_pc    = pc_source ? pc_target : pc_plus4;
  // Only a taken target can be misaligned; pc+4 from an aligned pc never is.
  assign misaligned = pc_source & (pc_target[1:0] != 2'b00);
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency imem and
// holds the instruction for control until retire.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            retire,
  input  logic            pc_source,
  input  logic [XLEN-1:0] pc_target,
  output logic            misalign_fault
);
  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc;
  logic [31:0]     instr_q;
  logic            fault_q, misaligned;

  pc_next u_pc_next (
    .pc        (pc_q),
    .pc_source (pc_source),
    .pc_target (pc_target),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: if (imem_ready)  state_d = WAIT;
      WAIT:  if (imem_rvalid) state_d = VALID;
      VALID: if (retire)      state_d = misaligned ? FAULT : FETCH;
      FAULT: state_d = FAULT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == FETCH) && !rst;
    instr_valid = (state_q == VALID);
    // Outside VALID control sees a NOP, so a stale word can never be decoded.
    instr       = instr_valid ? instr_q : NOP_INSTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      if (state_q == WAIT && imem_rvalid) instr_q <= imem_rdata;
      if (state_q == VALID && retire) begin
        if (misaligned) fault_q <= 1'b1;
        else            pc_q    <= next_pc;
      end
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign misalign_fault = fault_q;
  assign op             = instr[OP_MSB:OP_LSB];
  assign func3          = instr[F3_MSB:F3_LSB];
  assign func7          = instr[F7_MSB:F7_LSB];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_fetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] instr, pc, pc_plus4, pc_target = '0;
  logic [6:0]  op, func7;
  logic [2:0]  func3;
  logic        instr_valid, retire = 1'b0, pc_source = 1'b0, misalign_fault;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .func3(func3), .func7(func7),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .retire(retire), .pc_source(pc_source), .pc_target(pc_target),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one pending request, one outstanding read, or one held instruction.
  logic        armed = 1'b0;
  logic        m_req, m_held, m_fault;
  logic [31:0] m_pc, m_instr;

  always @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b1;
      m_pc    <= RST_PC;
      m_req   <= 1'b1;
      m_held  <= 1'b0;
      m_fault <= 1'b0;
      m_instr <= NOP_INSTR;
    end else if (armed && !m_fault) begin
      if (m_held) begin
        if (retire) begin
          m_held <= 1'b0;
          if (pc_source && pc_target[1:0] != 2'b00) m_fault <= 1'b1;
          else begin
            m_pc  <= pc_source ? pc_target : m_pc + 32'd4;
            m_req <= 1'b1;
          end
        end
      end else if (m_req) begin
        if (imem_ready) m_req <= 1'b0;
      end else if (imem_rvalid) begin
        m_held  <= 1'b1;
        m_instr <= imem_rdata;
      end
    end
  end

  logic [31:0] e_instr;
  always @(negedge clk) begin
    if (armed) begin
      e_instr = m_held ? m_instr : NOP_INSTR;
      chk("m_req", {31'd0, imem_req}, {31'd0, m_req && !m_fault && !rst});
      if (imem_req) chk("m_addr", imem_addr, m_pc);
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_held});
      chk("m_instr", instr, e_instr);
      chk("m_op", {25'd0, op}, {25'd0, e_instr[6:0]});
      chk("m_func3", {29'd0, func3}, {29'd0, e_instr[14:12]});
      chk("m_func7", {25'd0, func7}, {25'd0, e_instr[31:25]});
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc_plus4, m_pc + 32'd4);
      chk("m_fault", {31'd0, misalign_fault}, {31'd0, m_fault});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: stall ready nr cycles, delay rvalid nv cycles, land in VALID.
  task automatic fetch_one(input logic [31:0] d, input int nr, input int nv);
    logic [31:0] a;
    a = imem_addr;
    for (int i = 0; i < nr; i++) begin
      tick();
      chk("hold_req", {31'd0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, a);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 0; i < nv; i++) begin
      tick();
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
    chk("got_valid", {31'd0, instr_valid}, 32'd1);
    chk("got_instr", instr, d);
  endtask

  task automatic do_retire(input logic src, input logic [31:0] tgt);
    retire = 1'b1; pc_source = src; pc_target = tgt;
    tick();
    retire = 1'b0; pc_source = 1'b0; pc_target = '0;
  endtask

  initial begin
    // 1: reset and first fetch
    tick(); tick();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    fetch_one(32'h00A0_0093, 0, 0);
    chk("t1_op", {25'd0, op}, 32'h13);
    chk("t1_f3", {29'd0, func3}, 32'd0);
    chk("t1_f7", {25'd0, func7}, 32'd0);
    chk("t1_pc", pc, 32'd0);
    chk("t1_pc4", pc_plus4, 32'd4);

    // 2: sequential retires
    for (int i = 1; i <= 3; i++) begin
      do_retire(1'b0, 32'd0);
      chk("t2_req", {31'd0, imem_req}, 32'd1);
      chk("t2_addr", imem_addr, 32'(4 * i));
      fetch_one($urandom, 0, 0);
    end

    // 3: taken target
    do_retire(1'b1, 32'h0000_0100);
    chk("t3_addr", imem_addr, 32'h100);
    fetch_one(32'h0041_8233, 0, 1);
    chk("t3_pc", pc, 32'h100);
    chk("t3_f7", {25'd0, func7}, 32'd0);
    chk("t3_f3", {29'd0, func3}, 32'd0);

    // 4: misaligned target faults until reset
    do_retire(1'b1, 32'h0000_0102);
    chk("t4_fault", {31'd0, misalign_fault}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'b1; imem_rvalid = 1'b1; retire = 1'b1;
      tick();
      chk("t4_noreq", {31'd0, imem_req}, 32'd0);
      chk("t4_pc", pc, 32'h100);
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t4_clr", {31'd0, misalign_fault}, 32'd0);
    chk("t4_restart", imem_addr, RST_PC);

    // 5: backpressure, slow response, spurious rvalid in VALID
    fetch_one(32'hFE20_8EE3, 5, 7);
    chk("t5_op", {25'd0, op}, 32'h63);
    chk("t5_f7", {25'd0, func7}, 32'h7F);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    imem_rvalid = 1'b0;
    chk("t5_spur", instr, 32'hFE20_8EE3);

    // 6: reset in WAIT, reset in VALID, pc wrap
    do_retire(1'b0, 32'd0);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6w_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6w_instr", instr, NOP_INSTR);
    chk("t6w_addr", imem_addr, RST_PC);
    fetch_one(32'h1234_5678, 0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6v_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6v_instr", instr, NOP_INSTR);
    chk("t6v_req", {31'd0, imem_req}, 32'd1);
    fetch_one(32'h0000_0013, 0, 0);
    do_retire(1'b1, 32'hFFFF_FFFC);
    fetch_one(32'h0000_006F, 0, 0);
    chk("t6_pcmax", pc, 32'hFFFF_FFFC);
    chk("t6_wrap4", pc_plus4, 32'd0);
    do_retire(1'b0, 32'd0);
    chk("t6_wrap", imem_addr, 32'd0);
    chk("t6_nofault", {31'd0, misalign_fault}, 32'd0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      imem_ready  = $urandom_range(0, 2) == 0;
      imem_rvalid = $urandom_range(0, 2) == 0;
      imem_rdata  = $urandom;
      retire      = $urandom_range(0, 1) == 0;
      pc_source   = $urandom_range(0, 1) == 0;
      pc_target   = $urandom;
      if ($urandom_range(0, 7) != 0) pc_target[1:0] = 2'b00;
      tick();
    end
    rst = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; retire = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit.
- Owns the PC register and issues requests to a variable-latency instruction memory.
- Holds the returned instruction stable, split into op/func3/func7 fields for control, until the core signals retire.
- On retire, computes the next PC from pc_source and pc_target; a misaligned target raises a sticky fault.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented whenever no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req is high.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instr  out  32  held instruction word.
- op  out  7  instr[6:0].
- func3  out  3  instr[14:12].
- func7  out  7  instr[31:25].
- instr_valid  out  1  instr/op/func3/func7 are valid for the current pc.
- pc  out  XLEN  address of the held instruction.
- pc_plus4  out  XLEN  pc+4, modulo 2^XLEN.
- retire  in  1  core has executed the held instruction; advance.
- pc_source  in  1  0: next = pc+4; 1: next = pc_target.
- pc_target  in  XLEN  branch/jump target from the datapath.
- misalign_fault  out  1  sticky: taken target had target[1:0] != 0.

Behaviour:
- Reset (rst high at a clock edge) sets the following; reset mid-operation (any state) does the same and drops any outstanding request:
  - state = FETCH, pc = RESET_PC.
  - instr = NOP_INSTR, instr_valid = 0, misalign_fault = 0.
  - imem_req = 0 while rst is high.
- Instruction memory contract: imem shares rst, so no response arrives after reset for a pre-reset request.
- State FETCH:
  - imem_req = 1, imem_addr = pc.
  - imem_ready = 1 moves to WAIT; otherwise stay, holding req and addr stable.
- State WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 latches instr = imem_rdata and moves to VALID.
  - Response latency is unbounded; no timeout.
- State VALID:
  - instr_valid = 1; instr and pc are stable.
  - retire = 1 updates pc to the next PC and moves to FETCH. instr_valid is low from the next cycle; instr reverts to NOP_INSTR.
  - When pc_source = 1 and pc_target[1:0] != 0: pc is unchanged, misalign_fault is set, and the state moves to FAULT.
- State FAULT:
  - imem_req = 0, instr_valid = 0, instr = NOP_INSTR.
  - Exits only via rst.
- Ignored events:
  - retire outside VALID.
  - imem_rvalid outside WAIT.
  - pc_source and pc_target when retire = 0.
- Latency:
  - Request accepted at edge N, rvalid in cycle N+1 gives instr_valid in cycle N+2.
  - Best-case throughput is one instruction per 3 cycles when retire is asserted on the first VALID cycle.
  - retire asserted together with a new rvalid cannot occur; they belong to different states.
- Wrap-around: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000 with no fault.
- Compressed instructions are not supported; the alignment check uses bits [1:0].

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and NOP_INSTR constants.
  - Field-slice localparams for op/func3/func7.
  - fetch_state_t enum {FETCH, WAIT, VALID, FAULT}.
- One combinational sub-module, pc_next: inputs pc, pc_source, pc_target; outputs next_pc, pc_plus4, misaligned.
- The FSM and registers stay in fetch_unit.

Test Plan:
1. Reset, imem_ready = 1, rvalid one cycle later with rdata 32'h00A00093:
   - imem_addr = 0.
   - instr_valid rises two cycles after acceptance with op = 7'h13, func3 = 0, func7 = 0.
   - pc = 0, pc_plus4 = 4.
2. Sequential retire ×3 with pc_source = 0: the next imem_addr values are 4, 8, 12, each request issued the cycle after retire.
3. retire with pc_source = 1, pc_target = 32'h0000_0100: the next fetch uses imem_addr = 0x100 and pc = 0x100 when instr_valid rises.
4. pc_source = 1, pc_target = 32'h0000_0102 on retire:
   - misalign_fault = 1 the next cycle.
   - imem_req stays 0 for 20 cycles; pc is unchanged.
   - rst clears the fault and fetching restarts at RESET_PC.
5. Memory backpressure and delay:
   - imem_ready low for 5 cycles: imem_req and imem_addr are held stable.
   - rvalid delayed 7 cycles: instr_valid stays 0 throughout; a spurious rvalid in VALID does not change instr.
6. rst asserted in WAIT and in VALID: the next cycle shows instr_valid = 0 and instr = NOP_INSTR, then a fetch at RESET_PC. The pc = 32'hFFFF_FFFC sequential retire wraps to 0.
